// File: rtl/shift_pkg.sv
// Shared constants for the serial shift family (deserializer and the
// parallel-load shift register it pairs with).
//   DEFAULT_W  : default byte width in bits
//   LSB_FIRST  : bit order code, least significant bit arrives first
//   MSB_FIRST  : bit order code, most significant bit arrives first
package shift_pkg;

    localparam int   DEFAULT_W = 8;

    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/bit_counter.sv
// Bit position counter for the deserializer: counts accepted bits 0..W-1
// and wraps to 0 after the last bit of a byte.
//   clk   : clock, rising edge
//   nrst  : asynchronous active-low reset
//   clr   : frame restart, the current position is treated as 0
//   step  : one bit accepted this cycle
//   count : current bit position (registered)
//   first : the bit accepted this cycle (if any) is bit 0 of a byte
//   last  : strobe, the bit accepted this cycle is bit W-1
module bit_counter #(
    parameter int W = 8
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 clr,
    input  logic                                 step,
    output logic [((W > 1) ? $clog2(W) : 1)-1:0] count,
    output logic                                 first,
    output logic                                 last
);

    localparam int             CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  LAST_POS = CW'(W - 1);

    // Position seen by this cycle's bit: a same-edge restart makes it bit 0.
    logic [CW-1:0] cur;

    always_comb begin
        cur   = clr ? '0 : count;
        first = (cur == '0);
        last  = step && (cur == LAST_POS);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (step) begin
            count <= last ? '0 : cur + 1'b1;
        end else begin
            count <= cur;
        end
    end

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer with selectable bit order, a single
// holding register with valid/ready handoff and a sticky overflow flag.
//   clk       : clock, rising edge
//   nrst      : asynchronous active-low reset
//   sin       : serial data bit
//   sin_valid : accept sin this cycle
//   dir       : bit order, LSB_FIRST / MSB_FIRST, sampled on bit 0 of a byte
//   sync      : frame restart, discards a partial byte
//   q         : received byte
//   q_valid   : q holds an unconsumed byte
//   q_ready   : consumer takes q when q_valid & q_ready
//   busy      : partial byte in progress
//   ovf       : sticky, a completed byte was dropped
//   ovf_clr   : clears ovf (a same-edge set wins)
module shift_deser
    import shift_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         dir,
    input  logic         sync,
    output logic [W-1:0] q,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         busy,
    output logic         ovf,
    input  logic         ovf_clr
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [CW-1:0] count;
    logic          first;
    logic          last;
    logic [W-1:0]  sh;
    logic [W-1:0]  sh_next;
    logic          order_q;
    logic          order_eff;
    logic          load_ok;

    bit_counter #(.W(W)) u_bit_counter (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (sync),
        .step  (sin_valid),
        .count (count),
        .first (first),
        .last  (last)
    );

    // On bit 0 the live dir input applies; afterwards the latched order holds.
    always_comb begin
        order_eff = first ? dir : order_q;
        if (order_eff == MSB_FIRST) begin
            sh_next = {sh[W-2:0], sin};
        end else begin
            sh_next = {sin, sh[W-1:1]};
        end
        // Holding register can take a new byte if empty or being drained now.
        load_ok = !q_valid || q_ready;
        busy    = (count != '0);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sh      <= '0;
            order_q <= LSB_FIRST;
            q       <= '0;
            q_valid <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (sin_valid) begin
                sh <= sh_next;
                if (first) begin
                    order_q <= dir;
                end
            end

            if (last && load_ok) begin
                q       <= sh_next;
                q_valid <= 1'b1;
            end else if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end

            if (last && !load_ok) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_deser.sv
module tb_shift_deser;

    logic       clk;
    logic       nrst;
    logic       sin;
    logic       sin_valid;
    logic       dir;
    logic       sync;
    logic [7:0] q;
    logic       q_valid;
    logic       q_ready;
    logic       busy;
    logic       ovf;
    logic       ovf_clr;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];

    shift_deser #(.W(8)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .dir       (dir),
        .sync      (sync),
        .q         (q),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .busy      (busy),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a new byte is presented when q_valid rises, or when q_valid
    // stays high across an edge on which the previous byte was taken.
    initial begin : monitor
        logic prev_valid;
        logic prev_ready;
        logic [7:0] exp;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (q_valid && (!prev_valid || prev_ready)) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got q=%0h with no byte expected at %0t", q, $time);
                    end else begin
                        exp = sb.pop_front();
                        if (q !== exp) begin
                            errors++;
                            $display("FAIL sb_byte: got q=%0h expected %0h at %0t", q, exp, $time);
                        end
                    end
                end
                prev_valid = q_valid;
                prev_ready = q_ready;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    // Sends one 8-bit byte in the order given by d_first; d_rest is driven on
    // dir for bits 1..7 and must be ignored by the DUT.
    task automatic send_byte(input logic [7:0] val, input logic d_first, input logic d_rest,
                             input bit gap, input bit sync_first, input bit ready_last,
                             input bit expect_empty);
        for (int i = 0; i < 8; i++) begin
            sin       = d_first ? val[7-i] : val[i];
            sin_valid = 1'b1;
            dir       = (i == 0) ? d_first : d_rest;
            sync      = (i == 0) && sync_first;
            if (i == 7 && ready_last) q_ready = 1'b1;
            @(posedge clk);
            #1;
            sin_valid = 1'b0;
            sync      = 1'b0;
            if (i == 7 && ready_last) q_ready = 1'b0;
            check("busy_in_byte", {31'd0, busy}, {31'd0, (i != 7)});
            if (expect_empty && i < 7) check("q_valid_early", {31'd0, q_valid}, 32'd0);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            sin       = i[0];
            sin_valid = 1'b1;
            dir       = 1'b0;
            @(posedge clk);
            #1;
            sin_valid = 1'b0;
        end
    endtask

    task automatic consume();
        q_ready = 1'b1;
        @(posedge clk);
        #1;
        q_ready = 1'b0;
        check("q_valid_drained", {31'd0, q_valid}, 32'd0);
    endtask

    initial begin : stim
        nrst = 1'b0; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0;
        sync = 1'b0; q_ready = 1'b0; ovf_clr = 1'b0;
        #12;
        check("rst_q", {24'd0, q}, 32'd0);
        check("rst_q_valid", {31'd0, q_valid}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // LSB first A5, one cycle latency
        sb.push_back(8'hA5);
        send_byte(8'hA5, 1'b0, 1'b0, 0, 0, 0, 1);
        check("lsb_q_valid", {31'd0, q_valid}, 32'd1);
        consume();

        // MSB first A5 with idle cycles and dir flipping mid-byte
        sb.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, 1'b0, 1, 0, 0, 1);
        check("msb_gap_q_valid", {31'd0, q_valid}, 32'd1);
        consume();

        // Overflow: 3C held, C3 dropped
        sb.push_back(8'h3C);
        send_byte(8'h3C, 1'b0, 1'b0, 0, 0, 0, 0);
        send_byte(8'hC3, 1'b0, 1'b0, 0, 0, 0, 0);
        check("ovf_q_held", {24'd0, q}, 32'h3C);
        check("ovf_set", {31'd0, ovf}, 32'd1);
        check("ovf_q_valid", {31'd0, q_valid}, 32'd1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, ovf}, 32'd0);
        consume();

        // Handoff on the completion edge: no loss, no overflow
        sb.push_back(8'h3C);
        send_byte(8'h3C, 1'b0, 1'b0, 0, 0, 0, 0);
        sb.push_back(8'hC3);
        send_byte(8'hC3, 1'b0, 1'b0, 0, 0, 1, 0);
        check("handoff_q_valid", {31'd0, q_valid}, 32'd1);
        check("handoff_ovf", {31'd0, ovf}, 32'd0);
        consume();

        // Sync after 3 bits on an idle cycle
        send_bits(3);
        check("busy_partial", {31'd0, busy}, 32'd1);
        sync = 1'b1;
        @(posedge clk);
        #1;
        sync = 1'b0;
        check("busy_after_sync", {31'd0, busy}, 32'd0);
        check("sync_q_valid", {31'd0, q_valid}, 32'd0);
        sb.push_back(8'h81);
        send_byte(8'h81, 1'b0, 1'b1, 0, 0, 0, 1);
        consume();

        // Sync coinciding with bit 0 of the next byte
        send_bits(5);
        sb.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, 1'b0, 0, 1, 0, 1);
        consume();

        // Async reset mid-byte with a held byte and ovf set
        sb.push_back(8'h3C);
        send_byte(8'h3C, 1'b0, 1'b0, 0, 0, 0, 0);
        send_byte(8'hC3, 1'b0, 1'b0, 0, 0, 0, 0);
        send_bits(5);
        #5;
        nrst = 1'b0;
        sin = 1'b1;
        sin_valid = 1'b1;
        #1;
        check("arst_q", {24'd0, q}, 32'd0);
        check("arst_q_valid", {31'd0, q_valid}, 32'd0);
        check("arst_ovf", {31'd0, ovf}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        sin_valid = 1'b0;
        #2;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, 1'b1, 0, 0, 0, 1);
        consume();

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
